// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the three-channel UART TX scheduler.
// Holds the FSM state enum, channel indices and default burst length.
package tx_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    FETCH,
    SEND,
    ACK,
    DONE
  } state_t;

  localparam int CH_M2 = 0;
  localparam int CH_M5 = 1;
  localparam int CH_M7 = 2;

  localparam int MAX_BURST_DEF = 4;

  // Pointer after reset: m5 has top priority.
  localparam logic [2:0] PTR_RST = 3'b010;

  // Next channel in round-robin order m5 -> m7 -> m2 -> m5.
  function automatic logic [2:0] rr_next(
    input logic [2:0] g
  );
    return {g[1:0], g[2]};
  endfunction

endpackage

// File: rtl/tx_sched_rr_pick3.sv
// Combinational round-robin picker for three requesters.
// Ports: req (request vector), ptr (one-hot priority), gnt (one-hot grant).
module rr_pick3
  import tx_sched_pkg::*;
(
  input  logic [2:0] req,
  input  logic [2:0] ptr,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = '0;
    unique case (1'b1)
      ptr[CH_M2]: begin
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
      ptr[CH_M5]: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      ptr[CH_M7]: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/tx_sched.sv
// Round-robin scheduler sharing one UART TX between the m2/m5/m7 FIFOs.
// Ports: clk_24m, rst, ch_en, mX_empty/mX_data/mX_rden, tx_idle, tx_data,
// tx_start, grant, busy; TX_SCHED_STAT_EN adds stat_clr and cnt_m2/m5/m7.
module tx_sched
  import tx_sched_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int DW        = 8
) (
  input  logic          clk_24m,
  input  logic          rst,
  input  logic [2:0]    ch_en,
  input  logic          m2_empty,
  input  logic          m5_empty,
  input  logic          m7_empty,
  input  logic [DW-1:0] m2_data,
  input  logic [DW-1:0] m5_data,
  input  logic [DW-1:0] m7_data,
  output logic          m2_rden,
  output logic          m5_rden,
  output logic          m7_rden,
  input  logic          tx_idle,
  output logic [DW-1:0] tx_data,
  output logic          tx_start,
  output logic [2:0]    grant,
  output logic          busy
`ifdef TX_SCHED_STAT_EN
  ,
  input  logic          stat_clr,
  output logic [15:0]   cnt_m2,
  output logic [15:0]   cnt_m5,
  output logic [15:0]   cnt_m7
`endif
);

  state_t        state, state_n;
  logic [2:0]    ptr, ptr_n;
  logic [2:0]    grant_n;
  logic [2:0]    rden_q, rden_n;
  logic [3:0]    burst_cnt, burst_n;
  logic [DW-1:0] tx_data_n;
  logic          tx_start_n;
  logic [2:0]    req;
  logic [2:0]    pick;
  logic [DW-1:0] rd_data;

  assign req = ch_en & ~{m7_empty, m5_empty, m2_empty};

  assign m2_rden = rden_q[CH_M2];
  assign m5_rden = rden_q[CH_M5];
  assign m7_rden = rden_q[CH_M7];

  rr_pick3 u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick)
  );

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      grant[CH_M2]: rd_data = m2_data;
      grant[CH_M5]: rd_data = m5_data;
      grant[CH_M7]: rd_data = m7_data;
      default:      rd_data = '0;
    endcase
  end

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    grant_n    = grant;
    burst_n    = burst_cnt;
    rden_n     = '0;
    tx_start_n = 1'b0;
    tx_data_n  = tx_data;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_n = RD;
          grant_n = pick;
          burst_n = '0;
          rden_n  = pick;
        end
      end
      RD: state_n = FETCH;
      FETCH: begin
        // Start decided here so the pulse lands with the fresh byte.
        tx_data_n  = rd_data;
        tx_start_n = tx_idle;
        state_n    = SEND;
      end
      SEND: begin
        if (tx_start)     state_n = ACK;
        else if (tx_idle) tx_start_n = 1'b1;
      end
      ACK: begin
        if (!tx_idle) state_n = DONE;
      end
      DONE: begin
        if (tx_idle) begin
          burst_n = burst_cnt + 4'd1;
          if (burst_n < 4'(MAX_BURST) && |(req & grant)) begin
            state_n = RD;
            rden_n  = grant;
          end else begin
            state_n = IDLE;
            grant_n = '0;
            ptr_n   = rr_next(grant);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_24m) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= PTR_RST;
      grant     <= '0;
      burst_cnt <= '0;
      rden_q    <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      grant     <= grant_n;
      burst_cnt <= burst_n;
      rden_q    <= rden_n;
      tx_start  <= tx_start_n;
      tx_data   <= tx_data_n;
      busy      <= (state_n != IDLE);
    end
  end

`ifdef TX_SCHED_STAT_EN
  always_ff @(posedge clk_24m) begin
    if (rst || stat_clr) begin
      cnt_m2 <= '0;
      cnt_m5 <= '0;
      cnt_m7 <= '0;
    end else if (tx_start) begin
      if (grant[CH_M2]) cnt_m2 <= cnt_m2 + 16'd1;
      if (grant[CH_M5]) cnt_m5 <= cnt_m5 + 16'd1;
      if (grant[CH_M7]) cnt_m7 <= cnt_m7 + 16'd1;
    end
  end
`endif

endmodule
